pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  Fetch-side consumer of the D-stage compare flags (eq/neq/ltz/lez/gtz/gez) and branch/jump decode.
//  Owns the fetch PC register and presents PC to instruction fetch through a valid/ready handshake.
//  Resolves branches and jumps in D. Applies the redirect after the MIPS delay slot has been accepted.
//  Tracks a pending redirect while the fetch side is back-pressured.
// PARAMETERS
//  RESET_PC   32'h0000_3000   fetch PC loaded by reset
// PORTS
//  clk          in   1    clock; all state updates on its rising edge
//  reset        in   1    synchronous, active-high reset
//  fetch_pc     out  32   PC offered to fetch
//  fetch_valid  out  1    fetch_pc is valid
//  fetch_ready  in   1    fetch accepts fetch_pc this cycle (transfer = valid & ready)
//  br_valid     in   1    one-cycle pulse: D-stage control-transfer instruction resolved this cycle
//  br_type      in   4    encoding from pc_br_pkg: NONE,BEQ,BNE,BLTZ,BLEZ,BGTZ,BGEZ,J,JAL,JR,JALR
//  cmp_flags    in   6    {eq,neq,ltz,lez,gtz,gez}, from the D-stage comparator
//  br_pc        in   32   PC of the branch/jump instruction
//  br_imm       in   16   branch offset, in words
//  br_index     in   26   J/JAL instr_index
//  jr_target    in   32   forwarded rs value (JR/JALR)
//  squash       out  1    one-cycle pulse: the instruction accepted after the delay slot is wrong-path; D/F discard it
//  addr_err     out  1    one-cycle pulse: JR/JALR target had nonzero bits [1:0]
// BEHAVIOUR
//  Reset (highest priority over every other input)
//  - fetch_pc=RESET_PC; fetch_valid=0; squash=0; addr_err=0; state=BOOT; pend_target=0.
//  FSM
//  - BOOT -> RUN after one cycle, fetch_valid<=1.
//  - RUN:
//    - On a transfer, fetch_pc<=fetch_pc+4 (32-bit wrap, no flag).
//  - SLOT: a redirect is pending and the delay slot is not yet accepted.
//    - fetch_pc stays at br_pc+4.
//    - On a transfer, fetch_pc<=pend_target and state->RUN.
//    - br_valid in SLOT is a protocol violation: ignored; simulation assertion fires.
//  - fetch_valid stays 1 in RUN and SLOT. fetch_pc only changes on a transfer or a redirect.
//  Taken logic
//  - BEQ:eq, BNE:neq, BLTZ:ltz, BLEZ:lez, BGTZ:gtz, BGEZ:gez.
//  - J/JAL/JR/JALR: always taken. NONE: never taken.
//  Target arithmetic (32-bit, modulo 2^32)
//  - Branch: br_pc+4+({{14{imm[15]}},imm,2'b00}).
//  - J/JAL: {pc4[31:28],br_index,2'b00}, where pc4=br_pc+4.
//  - JR/JALR: {jr_target[31:2],2'b00}. addr_err=1 next cycle if jr_target[1:0]!=0; the redirect still occurs.
//  Redirect on a taken br_valid in RUN
//  - a) fetch_pc==br_pc+4 and no transfer this cycle: pend_target<=target, ->SLOT.
//  - b) fetch_pc==br_pc+4 and transfer this cycle (the delay slot goes now): fetch_pc<=target, stay RUN.
//  - c) fetch_pc==br_pc+8 (delay slot already accepted): fetch_pc<=target, squash=1 next cycle.
//     Any transfer in that cycle is also wrong-path and is covered by the same squash.
//  - d) any other fetch_pc: treated as c), and an assertion fires.
//  Other rules
//  - A not-taken br_valid has no effect on state or outputs.
//  - Redirect latency: target appears on fetch_pc 1 cycle after br_valid (cases b/c) or 1 cycle after delay-slot acceptance (case a).
//  - Reset mid-SLOT: the pending target is discarded and the unit restarts at RESET_PC.
// CONFIGURATION
//  BR_STATS_EN defined:
//  - Adds outputs br_taken_cnt[31:0] and br_total_cnt[31:0]; both reset to 0 and wrap.
//  - br_total_cnt counts every br_valid whose br_type is a conditional branch.
//  - br_taken_cnt counts those that are taken. J/JR variants are excluded.
//  BR_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  pc_br_pkg:
//  - br_type codes, BR_TYPE_W=4, flag bit positions within cmp_flags, RESET_PC default.
//  Sub-module br_decide (combinational):
//  - Inputs: br_type, cmp_flags, br_pc, br_imm, br_index, jr_target.
//  - Outputs: taken, target, misaligned.
//  Top-level pc_branch_unit holds the FSM, fetch_pc, pend_target, squash/addr_err regs and the optional counters.
// TESTING
//  1. Reset, then fetch_ready=1: fetch_valid=0 for 1 cycle, then fetch_pc=0x3000,0x3004,0x3008 on successive cycles.
//  2. BEQ br_pc=0x3000, imm=0x0003, eq=1, fetch_pc=0x3004, ready=0 for 2 cycles, then 1:
//     fetch_pc holds 0x3004, then becomes 0x3010; squash=0.
//  3. BNE neq=0 at br_pc=0x3000: fetch_pc continues 0x3004,0x3008; no squash.
//  4. J br_pc=0x3FFC, index=0x0000C00, fetch_pc already 0x4004:
//     next fetch_pc=0x00003000, squash=1 for exactly 1 cycle.
//  5. JR jr_target=0x00003012: fetch_pc -> 0x00003010 and addr_err=1 for 1 cycle.
//     BLTZ with imm=0xFFFF at br_pc=0x3008, ltz=1: target=0x3008.
//  6. Reset asserted while in SLOT: next cycle fetch_pc=0x3000, fetch_valid=0, pending target dropped.
//     With BR_STATS_EN, 3 BEQ (2 taken) + 1 J: total=3, taken=2.

Source files
------------

// File: rtl/pc_br_pkg.sv
// pc_br_pkg: branch type codes, compare-flag positions and reset PC shared by the
// fetch PC / branch unit and its decision logic.
package pc_br_pkg;
    localparam int BR_TYPE_W = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    // Bit positions inside cmp_flags = {eq,neq,ltz,lez,gtz,gez}
    localparam int F_EQ = 5;
    localparam int F_NEQ = 4;
    localparam int F_LTZ = 3;
    localparam int F_LEZ = 2;
    localparam int F_GTZ = 1;
    localparam int F_GEZ = 0;
    typedef enum logic [BR_TYPE_W-1:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLTZ = 4'd3,
        BR_BLEZ = 4'd4,
        BR_BGTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9,
        BR_JALR = 4'd10
    } br_type_e;
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_SLOT} state_e;
    function automatic logic is_cond(input logic [BR_TYPE_W-1:0] t);
        return t >= BR_BEQ && t <= BR_BGEZ;
    endfunction
endpackage

// File: rtl/br_decide.sv
// br_decide: combinational taken/target resolution for a D-stage branch or jump.
module br_decide
    import pc_br_pkg::*;
(
    input  logic [BR_TYPE_W-1:0] br_type,
    input  logic [5:0]           cmp_flags,
    input  logic [31:0]          br_pc,
    input  logic [15:0]          br_imm,
    input  logic [25:0]          br_index,
    input  logic [31:0]          jr_target,
    output logic                 taken,
    output logic [31:0]          target,
    output logic                 misaligned
);
    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] jr_tgt;
    logic        is_j;
    logic        is_jr;
    always_comb begin
        pc4 = br_pc + 32'd4;
        br_tgt = pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
        j_tgt = {pc4[31:28], br_index, 2'b00};
        jr_tgt = {jr_target[31:2], 2'b00};
        is_j = br_type == BR_J || br_type == BR_JAL;
        is_jr = br_type == BR_JR || br_type == BR_JALR;
        taken = (is_j || is_jr)     ? 1'b1 :
                br_type == BR_BEQ  ? cmp_flags[F_EQ] :
                br_type == BR_BNE  ? cmp_flags[F_NEQ] :
                br_type == BR_BLTZ ? cmp_flags[F_LTZ] :
                br_type == BR_BLEZ ? cmp_flags[F_LEZ] :
                br_type == BR_BGTZ ? cmp_flags[F_GTZ] :
                br_type == BR_BGEZ ? cmp_flags[F_GEZ] : 1'b0;
        target = is_jr ? jr_tgt : is_j ? j_tgt : br_tgt;
        misaligned = is_jr && jr_target[1:0] != 2'b00;
    end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: fetch PC owner; applies D-stage branch/jump redirects after the delay slot.
// Optional BR_STATS_EN adds conditional-branch taken/total counters.
module pc_branch_unit
    import pc_br_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [31:0]          fetch_pc,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    input  logic                 br_valid,
    input  logic [BR_TYPE_W-1:0] br_type,
    input  logic [5:0]           cmp_flags,
    input  logic [31:0]          br_pc,
    input  logic [15:0]          br_imm,
    input  logic [25:0]          br_index,
    input  logic [31:0]          jr_target,
    output logic                 squash,
    output logic                 addr_err
`ifdef BR_STATS_EN
    ,
    output logic [31:0]          br_taken_cnt,
    output logic [31:0]          br_total_cnt
`endif
);
    state_e      state;
    logic [31:0] pend_target;
    logic        taken;
    logic [31:0] target;
    logic        misaligned;
    logic        xfer;
    logic [31:0] slot_pc;
    br_decide u_decide (
        .br_type   (br_type),
        .cmp_flags (cmp_flags),
        .br_pc     (br_pc),
        .br_imm    (br_imm),
        .br_index  (br_index),
        .jr_target (jr_target),
        .taken     (taken),
        .target    (target),
        .misaligned(misaligned)
    );
    assign xfer = fetch_valid && fetch_ready;
    assign slot_pc = br_pc + 32'd4;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
            fetch_pc <= RESET_PC;
            fetch_valid <= 1'b0;
            pend_target <= 32'd0;
            squash <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            squash <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (br_valid && taken) begin
                        addr_err <= misaligned;
                        // Delay slot still at fetch: redirect now if it goes, else park the target
                        if (fetch_pc == slot_pc) begin
                            if (xfer) begin
                                fetch_pc <= target;
                            end else begin
                                pend_target <= target;
                                state <= ST_SLOT;
                            end
                        end else begin
                            fetch_pc <= target;
                            squash <= 1'b1;
                        end
                    end else if (xfer) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                ST_SLOT: begin
                    if (xfer) begin
                        fetch_pc <= pend_target;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end
`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            br_taken_cnt <= 32'd0;
            br_total_cnt <= 32'd0;
        end else if (br_valid && state != ST_SLOT && is_cond(br_type)) begin
            br_total_cnt <= br_total_cnt + 32'd1;
            br_taken_cnt <= br_taken_cnt + {31'd0, taken};
        end
    end
`endif
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(state == ST_SLOT && br_valid));
            assert (!(state == ST_RUN && br_valid && taken && fetch_pc != slot_pc && fetch_pc != slot_pc + 32'd4));
        end
    end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed vector table plus randomized run against a program-order reference model.
module tb_pc_branch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        br_valid;
    logic [3:0]  br_type;
    logic [5:0]  cmp_flags;
    logic [31:0] br_pc;
    logic [15:0] br_imm;
    logic [25:0] br_index;
    logic [31:0] jr_target;
    logic        squash;
    logic        addr_err;
`ifdef BR_STATS_EN
    logic [31:0] br_taken_cnt;
    logic [31:0] br_total_cnt;
`endif
    int checks = 0;
    int errors = 0;

    pc_branch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_pc   (fetch_pc),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .br_valid   (br_valid),
        .br_type    (br_type),
        .cmp_flags  (cmp_flags),
        .br_pc      (br_pc),
        .br_imm     (br_imm),
        .br_index   (br_index),
        .jr_target  (jr_target),
        .squash     (squash),
        .addr_err   (addr_err)
`ifdef BR_STATS_EN
        ,
        .br_taken_cnt(br_taken_cnt),
        .br_total_cnt(br_total_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, bv;
        logic [3:0]  ty;
        logic [5:0]  fl;
        logic [31:0] pc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] jr;
        logic [31:0] e_pc;
        logic        e_v, e_sq, e_ae;
    } vec_t;

    vec_t tv[24];

    function automatic vec_t mk(input logic rst, rdy, bv, input logic [3:0] ty, input logic [5:0] fl,
                                input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx,
                                input logic [31:0] jr, input logic [31:0] e_pc, input logic e_v, e_sq, e_ae);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.bv = bv; r.ty = ty; r.fl = fl; r.pc = pc; r.imm = imm;
        r.idx = idx; r.jr = jr; r.e_pc = e_pc; r.e_v = e_v; r.e_sq = e_sq; r.e_ae = e_ae;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, rdy, bv, input logic [3:0] ty, input logic [5:0] fl,
                         input logic [31:0] pc, input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
        reset = rst; fetch_ready = rdy; br_valid = bv; br_type = ty; cmp_flags = fl;
        br_pc = pc; br_imm = imm; br_index = idx; jr_target = jr;
    endtask

    // Reference model: architectural next-fetch address plus a queue of redirects waiting on their delay slot
    logic [31:0] m_pc;
    logic        m_v, e_sq, e_ae;
    logic [31:0] redir_q[$];
    int unsigned m_total, m_taken;

    function automatic logic ref_taken(input logic [3:0] t, input logic [5:0] f);
        case (t)
            4'd1: return f[5];
            4'd2: return f[4];
            4'd3: return f[3];
            4'd4: return f[2];
            4'd5: return f[1];
            4'd6: return f[0];
            4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input logic [3:0] t, input logic [31:0] pc, input logic [15:0] imm,
                                               input logic [25:0] idx, input logic [31:0] jr);
        logic signed [31:0] off;
        off = 32'($signed(imm));
        if (t >= 4'd9) return jr & ~32'h3;
        if (t >= 4'd7) return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
        return pc + 32'd4 + 32'(off * 4);
    endfunction

    task automatic model_step;
        logic [31:0] tgt;
        e_sq = 1'b0;
        e_ae = 1'b0;
        if (reset) begin
            m_pc = 32'h3000; m_v = 1'b0; redir_q.delete(); m_total = 0; m_taken = 0;
        end else if (!m_v) begin
            m_v = 1'b1;
        end else if (redir_q.size() != 0) begin
            if (fetch_ready) m_pc = redir_q.pop_front();
        end else begin
            if (br_valid && br_type >= 4'd1 && br_type <= 4'd6) begin
                m_total++;
                if (ref_taken(br_type, cmp_flags)) m_taken++;
            end
            if (br_valid && ref_taken(br_type, cmp_flags)) begin
                tgt = ref_target(br_type, br_pc, br_imm, br_index, jr_target);
                e_ae = br_type >= 4'd9 && jr_target[1:0] != 2'b00;
                if (m_pc == br_pc + 32'd4) begin
                    if (fetch_ready) m_pc = tgt;
                    else redir_q.push_back(tgt);
                end else begin
                    m_pc = tgt;
                    e_sq = 1'b1;
                end
            end else if (fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        //           rst rdy bv ty fl         pc          imm      idx        jr           e_pc         v  sq ae
        tv[0]  = mk(1, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 0, 0, 0);
        tv[1]  = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 1, 0, 0);
        tv[2]  = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3004, 1, 0, 0);
        tv[3]  = mk(0, 1, 1, 2, 6'b000000, 32'h3000, 16'h3,    26'h0,     32'h0,       32'h3008, 1, 0, 0);
        tv[4]  = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h300C, 1, 0, 0);
        tv[5]  = mk(1, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 0, 0, 0);
        tv[6]  = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 1, 0, 0);
        tv[7]  = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3004, 1, 0, 0);
        tv[8]  = mk(0, 0, 1, 1, 6'b100000, 32'h3000, 16'h0003, 26'h0,     32'h0,       32'h3004, 1, 0, 0);
        tv[9]  = mk(0, 0, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3004, 1, 0, 0);
        tv[10] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3010, 1, 0, 0);
        tv[11] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3014, 1, 0, 0);
        tv[12] = mk(0, 1, 1, 9, 6'b000000, 32'h3010, 16'h0,    26'h0,     32'h3012,    32'h3010, 1, 0, 1);
        tv[13] = mk(0, 0, 1, 3, 6'b001000, 32'h3008, 16'hFFFF, 26'h0,     32'h0,       32'h3008, 1, 1, 0);
        tv[14] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h300C, 1, 0, 0);
        tv[15] = mk(0, 1, 1, 9, 6'b000000, 32'h3008, 16'h0,    26'h0,     32'h4000,    32'h4000, 1, 0, 0);
        tv[16] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h4004, 1, 0, 0);
        tv[17] = mk(0, 1, 1, 7, 6'b000000, 32'h3FFC, 16'h0,    26'h0C00,  32'h0,       32'h3000, 1, 1, 0);
        tv[18] = mk(0, 0, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 1, 0, 0);
        tv[19] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3004, 1, 0, 0);
        tv[20] = mk(0, 0, 1, 1, 6'b100000, 32'h3000, 16'h0010, 26'h0,     32'h0,       32'h3004, 1, 0, 0);
        tv[21] = mk(1, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 0, 0, 0);
        tv[22] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3000, 1, 0, 0);
        tv[23] = mk(0, 1, 0, 0, 6'b000000, 32'h0,    16'h0,    26'h0,     32'h0,       32'h3004, 1, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            drive(tv[i].rst, tv[i].rdy, tv[i].bv, tv[i].ty, tv[i].fl, tv[i].pc, tv[i].imm, tv[i].idx, tv[i].jr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d fetch_pc", i), fetch_pc, tv[i].e_pc);
            chk($sformatf("vec%0d fetch_valid", i), {31'd0, fetch_valid}, {31'd0, tv[i].e_v});
            chk($sformatf("vec%0d squash", i), {31'd0, squash}, {31'd0, tv[i].e_sq});
            chk($sformatf("vec%0d addr_err", i), {31'd0, addr_err}, {31'd0, tv[i].e_ae});
        end
`ifdef BR_STATS_EN
        // Three BEQ (two taken) and one J, each with the delay slot leaving in the same cycle
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, (k == 3) ? 4'd7 : 4'd1, (k == 1) ? 6'b000000 : 6'b100000,
                  fetch_pc - 32'd4, 16'h0, 26'h0C00, 32'h0);
            @(posedge clk); #1;
        end
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("stats total", br_total_cnt, 32'd3);
        chk("stats taken", br_taken_cnt, 32'd2);
`endif
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic issue;
            issue = !reset && m_v && redir_q.size() == 0 && ($urandom % 4 == 0);
            br_valid = issue;
            br_type = 4'($urandom_range(0, 10));
            cmp_flags = 6'($urandom);
            br_pc = m_pc - (($urandom % 2 == 0) ? 32'd4 : 32'd8);
            br_imm = 16'($urandom);
            br_index = 26'($urandom);
            jr_target = $urandom;
            fetch_ready = ($urandom % 3) != 0;
            model_step();
            @(posedge clk);
            #1;
            chk("rand fetch_pc", fetch_pc, m_pc);
            chk("rand fetch_valid", {31'd0, fetch_valid}, {31'd0, m_v});
            chk("rand squash", {31'd0, squash}, {31'd0, e_sq});
            chk("rand addr_err", {31'd0, addr_err}, {31'd0, e_ae});
            reset = ($urandom % 250) == 0;
        end
`ifdef BR_STATS_EN
        chk("rand stats total", br_total_cnt, m_total);
        chk("rand stats taken", br_taken_cnt, m_taken);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
